// File: rtl/delay_tap_reader_if.sv
// rtl/delay_tap_reader_if.sv - tap stream between the delay line reader and the MAC stage
// Purpose: carries one delayed sample per handshake from the history buffer
//          to the shared multiply-accumulate stage.
// Signals:
//   tap_data_o   delayed sample x[n-k]
//   tap_idx_o    tap index k
//   tap_valid_o  tap_data_o/tap_idx_o valid
//   tap_last_o   marks k = TAPS-1
//   tap_ready_i  consumer accepts the current tap
// Modports: master = reader (drives taps), slave = MAC (drives ready).
interface delay_tap_reader_if #(
   parameter int W    = 16,
   parameter int TAPS = 8,
   parameter int AW   = $clog2(TAPS)
);
   logic [W-1:0]  tap_data_o;
   logic [AW-1:0] tap_idx_o;
   logic          tap_valid_o;
   logic          tap_last_o;
   logic          tap_ready_i;

   modport master (
      output tap_data_o,
      output tap_idx_o,
      output tap_valid_o,
      output tap_last_o,
      input  tap_ready_i
   );

   modport slave (
      input  tap_data_o,
      input  tap_idx_o,
      input  tap_valid_o,
      input  tap_last_o,
      output tap_ready_i
   );
endinterface

// File: rtl/delay_tap_reader.sv
// rtl/delay_tap_reader.sv - circular sample history read out one tap per handshake
// Purpose: stores each accepted sample in a TAPS-deep circular buffer and
//          streams x[n], x[n-1], ..., x[n-TAPS+1] to the MAC stage.
// Ports:
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset
//   en_i     new-sample strobe, data_in valid while high
//   data_in  incoming sample
//   tap      tap stream (master modport)
//   busy_o   sweep in progress
//   drop_o   one-cycle pulse after a rejected sample
module delay_tap_reader #(
   parameter int W    = 16,
   parameter int TAPS = 8,
   parameter int AW   = $clog2(TAPS)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic [W-1:0]         data_in,
   delay_tap_reader_if.master   tap,
   output logic                 busy_o,
   output logic                 drop_o
);

   typedef enum logic {IDLE, SWEEP} state_t;

   localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

   state_t        state;
   logic [W-1:0]  mem [TAPS];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic [AW-1:0] k;

   logic          hs;
   logic          final_hs;
   logic          accept;
   logic [AW-1:0] rp_dec;
   logic [AW-1:0] wp_inc;

   assign hs       = tap.tap_valid_o & tap.tap_ready_i;
   assign final_hs = (state == SWEEP) && hs && (k == LAST);
   // A new sample is taken when idle, or exactly on the cycle the last tap
   // leaves, so back-to-back sweeps have no bubble.
   assign accept   = en_i && ((state == IDLE) || final_hs);

   // Explicit wrap so depths that are not powers of two index correctly.
   assign rp_dec = (rp == '0)   ? LAST : rp - 1'b1;
   assign wp_inc = (wp == LAST) ? '0   : wp + 1'b1;

   assign tap.tap_idx_o = k;
   assign busy_o        = (state == SWEEP);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < TAPS; i++) begin
            mem[i] <= '0;
         end
         state           <= IDLE;
         wp              <= '0;
         rp              <= '0;
         k               <= '0;
         tap.tap_data_o  <= '0;
         tap.tap_valid_o <= 1'b0;
         tap.tap_last_o  <= 1'b0;
         drop_o          <= 1'b0;
      end else begin
         drop_o <= en_i && !accept;
         if (accept) begin
            // The newest tap is forwarded straight from data_in since the
            // buffer write lands on the same edge.
            mem[wp]         <= data_in;
            rp              <= wp;
            wp              <= wp_inc;
            k               <= '0;
            tap.tap_data_o  <= data_in;
            tap.tap_valid_o <= 1'b1;
            tap.tap_last_o  <= 1'b0;
            state           <= SWEEP;
         end else if ((state == SWEEP) && hs) begin
            if (k == LAST) begin
               tap.tap_valid_o <= 1'b0;
               tap.tap_last_o  <= 1'b0;
               state           <= IDLE;
            end else begin
               k              <= k + 1'b1;
               rp             <= rp_dec;
               tap.tap_data_o <= mem[rp_dec];
               tap.tap_last_o <= ((k + 1'b1) == LAST);
            end
         end
      end
   end

endmodule

// File: tb/tb_delay_tap_reader.sv
// tb/tb_delay_tap_reader.sv - scoreboard bench for delay_tap_reader
module tb_delay_tap_reader;

   localparam int W    = 16;
   localparam int TAPS = 8;
   localparam int AW   = $clog2(TAPS);

   typedef struct {
      logic [W-1:0]  d;
      logic [AW-1:0] i;
      logic          l;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         en;
   logic [W-1:0] data;
   logic         busy;
   logic         drop;

   int checks = 0;
   int errors = 0;
   int busy_cnt = 0;
   int drop_cnt = 0;

   exp_t         sb[$];
   logic [W-1:0] hist[$];

   delay_tap_reader_if #(.W(W), .TAPS(TAPS)) tif ();

   delay_tap_reader #(.W(W), .TAPS(TAPS)) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .en_i   (en),
      .data_in(data),
      .tap    (tif),
      .busy_o (busy),
      .drop_o (drop)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Sample at the falling edge, then advance past the next rising edge.
   task automatic cyc();
      exp_t e;
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (drop === 1'b1) drop_cnt++;
      if (tif.tap_valid_o === 1'b1 && tif.tap_ready_i === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_tap", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("tap_data", 32'(tif.tap_data_o), 32'(e.d));
            check("tap_idx", 32'(tif.tap_idx_o), 32'(e.i));
            check("tap_last", 32'(tif.tap_last_o), 32'(e.l));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic push_sample(input logic [W-1:0] v);
      exp_t         e;
      logic [W-1:0] dummy;
      hist.push_front(v);
      if (hist.size() > TAPS) dummy = hist.pop_back();
      for (int kk = 0; kk < TAPS; kk++) begin
         e.d = (kk < hist.size()) ? hist[kk] : '0;
         e.i = AW'(kk);
         e.l = (kk == TAPS - 1);
         sb.push_back(e);
      end
   endtask

   task automatic feed(input logic [W-1:0] v);
      en   = 1'b1;
      data = v;
      push_sample(v);
      cyc();
      en   = 1'b0;
   endtask

   task automatic drain();
      int budget = 60;
      while ((sb.size() != 0 || tif.tap_valid_o === 1'b1) && budget > 0) begin
         cyc();
         budget--;
      end
      if (budget == 0) check("drain_timeout", 32'd1, 32'd0);
   endtask

   task automatic wait_idx(input int n);
      int budget = 40;
      while (!(tif.tap_valid_o === 1'b1 && tif.tap_idx_o === AW'(n)) && budget > 0) begin
         cyc();
         budget--;
      end
      if (budget == 0) check("wait_idx_timeout", 32'd1, 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      cyc();
      sb.delete();
      hist.delete();
      rst = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_valid"}, 32'(tif.tap_valid_o), 32'd0);
      check({tag, "_last"}, 32'(tif.tap_last_o), 32'd0);
      check({tag, "_data"}, 32'(tif.tap_data_o), 32'd0);
      check({tag, "_idx"}, 32'(tif.tap_idx_o), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_drop"}, 32'(drop), 32'd0);
   endtask

   initial begin
      logic [W-1:0] held;
      int           drops_before;

      rst = 1'b1;
      en = 1'b0;
      data = '0;
      tif.tap_ready_i = 1'b1;
      #1;
      do_reset();
      check_zero("reset");

      // single sample into an empty history
      busy_cnt = 0;
      feed(16'd5);
      drain();
      check("busy_cycles", 32'(busy_cnt), 32'd8);

      // successive samples with idle gaps
      feed(16'd1);
      drain();
      feed(16'd2);
      drain();
      feed(16'd3);
      drain();

      // backpressure at k=2
      feed(16'd4);
      wait_idx(2);
      tif.tap_ready_i = 1'b0;
      held = tif.tap_data_o;
      for (int c = 0; c < 3; c++) begin
         cyc();
         check("bp_data", 32'(tif.tap_data_o), 32'(held));
         check("bp_idx", 32'(tif.tap_idx_o), 32'd2);
         check("bp_valid", 32'(tif.tap_valid_o), 32'd1);
      end
      tif.tap_ready_i = 1'b1;
      drain();

      // rejected sample mid-sweep
      feed(16'd6);
      wait_idx(4);
      en   = 1'b1;
      data = 16'h007F;
      cyc();
      en   = 1'b0;
      check("drop_pulse", 32'(drop), 32'd1);
      cyc();
      check("drop_clear", 32'(drop), 32'd0);
      drain();
      feed(16'd8);
      drain();

      // wrap-around with back-to-back sweeps
      do_reset();
      drop_cnt = 0;
      drops_before = drop_cnt;
      feed(16'd1);
      for (int s = 2; s <= 11; s++) begin
         wait_idx(TAPS - 1);
         en   = 1'b1;
         data = W'(s);
         push_sample(W'(s));
         cyc();
         en   = 1'b0;
         check("b2b_busy", 32'(busy), 32'd1);
         check("b2b_valid", 32'(tif.tap_valid_o), 32'd1);
         check("b2b_idx", 32'(tif.tap_idx_o), 32'd0);
      end
      drain();
      check("b2b_drops", 32'(drop_cnt - drops_before), 32'd0);

      // reset in mid-sweep
      feed(16'd12);
      wait_idx(5);
      rst = 1'b1;
      cyc();
      sb.delete();
      hist.delete();
      rst = 1'b0;
      check_zero("midreset");
      feed(16'd9);
      drain();
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
